// File: rtl/hs32_defs.sv
// ----------------------------------------------------------------------------
// hs32_defs -- constants shared across the HS32 core.
//
//   HS32_WORD       machine word width in bits
//   HS32_INST_STEP  byte distance between consecutive instructions
//   HS32_RESET_PC   default program counter value after reset
//   hs32_word_t     one machine word
//   hs32_next_pc()  sequential successor of a PC, wrapping modulo 2^32
// ----------------------------------------------------------------------------
package hs32_defs;

  localparam int unsigned HS32_WORD      = 32;
  localparam int unsigned HS32_INST_STEP = 4;

  typedef logic [HS32_WORD-1:0] hs32_word_t;

  localparam hs32_word_t HS32_RESET_PC = '0;

  function automatic hs32_word_t hs32_next_pc(input hs32_word_t pc);
    return pc + hs32_word_t'(HS32_INST_STEP);
  endfunction

endpackage

// File: rtl/hs32_fifo.sv
// ----------------------------------------------------------------------------
// hs32_fifo -- small synchronous FIFO used as the fetch prefetch queue and by
// the LSU.
//
// Parameters:
//   DEPTH   number of entries (1 or more)
//   DATA_W  entry width
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous active-low reset
//   push    write din at the tail (ignored when full unless popping too)
//   pop     remove the head entry (ignored when empty)
//   clear   empty the FIFO; overrides push and pop in the same cycle
//   din     write data
//   dout    head entry; while empty it holds the last head value shown
//   count   number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module hs32_fifo
  import hs32_defs::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = HS32_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              not_empty;
  logic              do_push;
  logic              do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    not_empty = (count_q != '0);
    do_pop    = pop && not_empty;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    do_push   = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Track whatever is shown at the head so dout stays put once empty.
    hold_d  = not_empty ? mem_q[rptr_q] : hold_q;

    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Storage carries no reset: an entry is only visible after it was written.
  always_ff @(posedge clk) begin
    if (!clear && do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = not_empty ? mem_q[rptr_q] : hold_q;
  assign count = count_q;

endmodule

// File: rtl/hs32_fetch.sv
// ----------------------------------------------------------------------------
// hs32_fetch -- HS32 instruction fetch stage.
//
// Holds the PC, issues word reads on the memory request/ready bus, buffers
// returned words and hands them to decode through the reqd/rdyd handshake.
// A flush from exec discards queued and in-flight work and restarts at newpc.
//
// Build option:
//   HS32_PREFETCH_EN  defined   -> prefetch queue of DEPTH entries
//                     undefined -> single-entry buffer, DEPTH ignored
//
// Parameters:
//   RESET_PC  PC after reset
//   DEPTH     prefetch queue entries (power of two, >= 2)
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   flush  one-cycle redirect pulse; newpc sampled with it
//   newpc  redirect target
//   addr   memory read address (the PC register)
//   dtr    memory read data, valid when reqm && rdym
//   reqm   memory read request
//   rdym   memory ready
//   instd  instruction to decode (queue head)
//   rdyd   instd valid
//   reqd   decode takes an instruction
// ----------------------------------------------------------------------------
module hs32_fetch
  import hs32_defs::*;
#(
  parameter hs32_word_t  RESET_PC = HS32_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [HS32_WORD-1:0] newpc,
  output logic [HS32_WORD-1:0] addr,
  input  logic [HS32_WORD-1:0] dtr,
  output logic                 reqm,
  input  logic                 rdym,
  output logic [HS32_WORD-1:0] instd,
  output logic                 rdyd,
  input  logic                 reqd
);

`ifdef HS32_PREFETCH_EN
  localparam int unsigned QDEPTH = DEPTH;
`else
  localparam int unsigned QDEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("hs32_fetch: DEPTH must be a power of two and at least 2");
  end

  hs32_word_t        pc_q, pc_d;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              pop;

  always_comb begin
    // reset gating drops the request the moment reset asserts, mid-cycle.
    reqm   = reset && !flush && (count < CNT_W'(QDEPTH));
    rdyd   = (count != '0);
    accept = reqm && rdym;
    // Flush discards a pop in the same cycle; the queue clear also overrides it.
    pop    = reqd && rdyd && !flush;

    pc_d = pc_q;
    if (flush)       pc_d = newpc;
    else if (accept) pc_d = hs32_next_pc(pc_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign addr = pc_q;

  // Registered storage between dtr and instd: no combinational bypass.
  hs32_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W (HS32_WORD)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .clear (flush),
    .din   (dtr),
    .dout  (instd),
    .count (count)
  );

endmodule

// File: tb/tb_hs32_fetch.sv
module tb_hs32_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef HS32_PREFETCH_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        rdym  = 1'b0;
  logic        reqd  = 1'b0;
  logic [31:0] newpc = '0;
  logic [31:0] dtr   = '0;
  logic [31:0] addr;
  logic [31:0] instd;
  logic        reqm;
  logic        rdyd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_last;
  logic [31:0] sbq [$];

  typedef struct {
    logic        rdym;
    logic        reqd;
    logic        flush;
    logic [31:0] newpc;
    logic [31:0] e_addr;
    logic        e_reqm;
    logic        e_rdyd;
    logic [31:0] e_instd;
  } row_t;

  row_t tbl [11];

  hs32_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .newpc (newpc),
    .addr  (addr),
    .dtr   (dtr),
    .reqm  (reqm),
    .rdym  (rdym),
    .instd (instd),
    .rdyd  (rdyd),
    .reqd  (reqd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h4200_0000 | (a & 32'h0000_FFFF);
  endfunction

  function automatic row_t mk(input logic i_rdym, input logic i_reqd, input logic i_flush,
                              input logic [31:0] i_newpc, input logic [31:0] e_addr,
                              input logic e_reqm, input logic e_rdyd, input logic [31:0] e_instd);
    row_t r;
    r.rdym = i_rdym; r.reqd = i_reqd; r.flush = i_flush; r.newpc = i_newpc;
    r.e_addr = e_addr; r.e_reqm = e_reqm; r.e_rdyd = e_rdyd; r.e_instd = e_instd;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_last = '0;
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; newpc = '0; rdym = 1'b1; reqd = 1'b1; dtr = 32'h1234_5678;
    #1;
    check1 ("rst_reqm",  reqm,  1'b0);
    check1 ("rst_rdyd",  rdyd,  1'b0);
    check32("rst_addr",  addr,  RST_PC);
    check32("rst_instd", instd, 32'h0);
    @(negedge clk);
    #1;
    check1("rst_reqm_held", reqm, 1'b0);
    rdym  = 1'b0;
    reqd  = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs after the falling edge, compare against the
  // scoreboard, then advance the model to what the next rising edge does.
  task automatic step(input logic i_rdym, input logic i_reqd, input logic i_flush,
                      input logic [31:0] i_newpc);
    logic m_reqm, m_acc, m_pop;
    @(negedge clk);
    rdym  = i_rdym;
    reqd  = i_reqd;
    flush = i_flush;
    newpc = i_newpc;
    dtr   = i_rdym ? word_at(addr) : 32'hDEAD_BEEF;
    #1;
    m_reqm = (sbq.size() < QD) && !i_flush;
    check1 ("sb_reqm", reqm, m_reqm);
    check1 ("sb_rdyd", rdyd, sbq.size() != 0);
    check32("sb_addr", addr, m_pc);
    if (sbq.size() != 0) begin
      check32("sb_instd", instd, sbq[0]);
      m_last = sbq[0];
    end else begin
      check32("sb_instd_hold", instd, m_last);
    end
    m_acc = m_reqm && i_rdym;
    m_pop = i_reqd && (sbq.size() != 0);
    if (i_flush) begin
      sbq.delete();
      m_pc = i_newpc;
    end else begin
      if (m_pop) void'(sbq.pop_front());
      if (m_acc) begin
        sbq.push_back(word_at(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
`ifdef HS32_PREFETCH_EN
    tbl[0]  = mk(1, 1, 0, 0,          32'h1000, 1, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 0,          32'h1004, 1, 1, 32'h4200_1000);
    tbl[2]  = mk(1, 1, 0, 0,          32'h1008, 1, 1, 32'h4200_1004);
    tbl[3]  = mk(0, 1, 0, 0,          32'h100C, 1, 1, 32'h4200_1008);
    tbl[4]  = mk(0, 1, 0, 0,          32'h100C, 1, 0, 32'h4200_1008);
    tbl[5]  = mk(0, 1, 0, 0,          32'h100C, 1, 0, 32'h4200_1008);
    tbl[6]  = mk(1, 1, 0, 0,          32'h100C, 1, 0, 32'h4200_1008);
    tbl[7]  = mk(1, 0, 0, 0,          32'h1010, 1, 1, 32'h4200_100C);
    tbl[8]  = mk(1, 1, 1, 32'h2000,   32'h1014, 0, 1, 32'h4200_100C);
    tbl[9]  = mk(1, 1, 0, 0,          32'h2000, 1, 0, 32'h4200_100C);
    tbl[10] = mk(1, 1, 0, 0,          32'h2004, 1, 1, 32'h4200_2000);
`else
    tbl[0]  = mk(1, 1, 0, 0,          32'h1000, 1, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 0,          32'h1004, 0, 1, 32'h4200_1000);
    tbl[2]  = mk(1, 1, 0, 0,          32'h1004, 1, 0, 32'h4200_1000);
    tbl[3]  = mk(0, 1, 0, 0,          32'h1008, 0, 1, 32'h4200_1004);
    tbl[4]  = mk(0, 1, 0, 0,          32'h1008, 1, 0, 32'h4200_1004);
    tbl[5]  = mk(0, 1, 0, 0,          32'h1008, 1, 0, 32'h4200_1004);
    tbl[6]  = mk(1, 1, 0, 0,          32'h1008, 1, 0, 32'h4200_1004);
    tbl[7]  = mk(1, 0, 0, 0,          32'h100C, 0, 1, 32'h4200_1008);
    tbl[8]  = mk(1, 1, 1, 32'h2000,   32'h100C, 0, 1, 32'h4200_1008);
    tbl[9]  = mk(1, 1, 0, 0,          32'h2000, 1, 0, 32'h4200_1008);
    tbl[10] = mk(1, 1, 0, 0,          32'h2004, 0, 1, 32'h4200_2000);
`endif

    // Reset release, steady streaming, memory stall, flush with a busy queue.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rdym, tbl[i].reqd, tbl[i].flush, tbl[i].newpc);
      check32($sformatf("tbl%0d_addr", i),  addr,  tbl[i].e_addr);
      check1 ($sformatf("tbl%0d_reqm", i),  reqm,  tbl[i].e_reqm);
      check1 ($sformatf("tbl%0d_rdyd", i),  rdyd,  tbl[i].e_rdyd);
      check32($sformatf("tbl%0d_instd", i), instd, tbl[i].e_instd);
    end

    // Backpressure: fill the queue with decode stalled, then pop once.
    do_reset();
    for (int i = 0; i < QD; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check1 ("bp_full_reqm", reqm, 1'b0);
    check32("bp_full_addr", addr, RST_PC + 32'(4 * QD));
    step(1, 1, 0, 0);
    check1 ("bp_pop_cycle_reqm", reqm, 1'b0);
    step(1, 0, 0, 0);
    check1 ("bp_after_pop_reqm", reqm, 1'b1);

    // PC wrap-around at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check32("wrap_addr_before", addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    check32("wrap_addr_after", addr, 32'h0000_0000);
    check1 ("wrap_rdyd",       rdyd, 1'b1);
    check32("wrap_instd",      instd, 32'h4200_FFFC);

    // Asynchronous reset in the middle of a stalled cycle.
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check1("stall_rdyd_before_rst", rdyd, 1'b1);
    reset = 1'b0;
    #1;
    check1 ("async_rst_reqm",  reqm,  1'b0);
    check1 ("async_rst_rdyd",  rdyd,  1'b0);
    check32("async_rst_addr",  addr,  RST_PC);
    check32("async_rst_instd", instd, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Random traffic against the scoreboard, with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      logic        r_rdym, r_reqd, r_flush;
      logic [31:0] r_pc;
      r_rdym  = ($urandom_range(0, 3) != 0);
      r_reqd  = ($urandom_range(0, 2) != 0);
      r_flush = ($urandom_range(0, 15) == 0);
      r_pc    = $urandom & 32'hFFFF_FFFC;
      step(r_rdym, r_reqd, r_flush, r_pc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
